fixed_linear_weight_buffer: RTL and testbench

// Upstream weight source for fixed_linear. Captures one full weight matrix, arriving as

---
 rtl/fixed_linear_weight_buffer.sv | 157 +++++++++++++++
 tb/tb_fixed_linear_weight_buffer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_linear_weight_buffer.sv
// -----------------------------------------------------------------------------
// fixed_linear_weight_buffer
//
// Purpose:
//   Holds one complete weight matrix for fixed_linear. The matrix arrives as
//   transposed, partitioned tiles on the load port and is stored in a register
//   array. Once the last tile is captured, the stored tiles are replayed in
//   load order on the output port, once per data row (ROWS passes). After the
//   final pass the load port reopens for the next matrix. Loading and replay
//   never overlap, so a new matrix can never overwrite tiles still in use.
//
// Ports:
//   clk              clock
//   rst              synchronous reset, active-low (0 = reset)
//   weight_in        load tile, element [P_IN*i+j] = output i, input j
//   weight_in_valid  load tile valid
//   weight_in_ready  buffer accepts a load tile (high only while loading)
//   weight           replayed tile, same layout as weight_in
//   weight_valid     replayed tile valid (high only while streaming)
//   weight_ready     downstream accepts the replayed tile
//   weight_pass_last marks the last tile of a replay pass
//
// Tile element e occupies bits [WEIGHT_PRECISION_0*e +: WEIGHT_PRECISION_0].
// -----------------------------------------------------------------------------
module fixed_linear_weight_buffer #(
    parameter int WEIGHT_PRECISION_0          = 16,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 2,
    parameter int WEIGHT_PARALLELISM_DIM_0    = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 4,
    parameter int WEIGHT_TENSOR_SIZE_DIM_1    = 8,
    parameter int ROWS                        = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_0-1:0] weight_in,
    input  logic                                  weight_in_valid,
    output logic                                  weight_in_ready,
    output logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_0-1:0] weight,
    output logic                                  weight_valid,
    input  logic                                  weight_ready,
    output logic                                  weight_pass_last
);

    localparam int IN_DEPTH  = DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0;
    localparam int OUT_DEPTH = WEIGHT_TENSOR_SIZE_DIM_1 / WEIGHT_PARALLELISM_DIM_0;
    localparam int NUM_TILES = IN_DEPTH * OUT_DEPTH;
    localparam int TILE      = WEIGHT_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_0;
    localparam int TILE_W    = WEIGHT_PRECISION_0 * TILE;
    localparam int PTR_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int PASS_W    = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [PTR_W-1:0]  LAST_TILE = PTR_W'(NUM_TILES - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(ROWS - 1);

    typedef enum logic {
        S_LOAD   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [PASS_W-1:0]  pass_cnt;
    logic [PASS_W-1:0]  pass_cnt_next;
    logic               load_fire;
    logic               stream_fire;

    logic [TILE_W-1:0]  mem [NUM_TILES];

    // Handshakes are qualified by state so a valid held high during the
    // opposite phase has no effect.
    assign load_fire   = (state == S_LOAD)   && weight_in_valid;
    assign stream_fire = (state == S_STREAM) && weight_ready;

    assign weight_in_ready  = (state == S_LOAD);
    assign weight_valid     = (state == S_STREAM);
    assign weight_pass_last = (state == S_STREAM) && (rd_ptr == LAST_TILE);

    // Combinational read: the tile at rd_ptr is presented with no added
    // latency. Written as a compare-select so a single-tile build needs no
    // zero-width index.
    always_comb begin
        weight = mem[0];
        for (int k = 0; k < NUM_TILES; k++) begin
            if (rd_ptr == PTR_W'(k)) begin
                weight = mem[k];
            end
        end
    end

    // Next-state and pointer logic.
    always_comb begin
        state_next    = state;
        wr_ptr_next   = wr_ptr;
        rd_ptr_next   = rd_ptr;
        pass_cnt_next = pass_cnt;

        unique case (state)
            S_LOAD: begin
                if (load_fire) begin
                    if (wr_ptr == LAST_TILE) begin
                        wr_ptr_next = '0;
                        state_next  = S_STREAM;
                    end else begin
                        wr_ptr_next = wr_ptr + PTR_W'(1);
                    end
                end
            end
            S_STREAM: begin
                if (stream_fire) begin
                    if (rd_ptr == LAST_TILE) begin
                        rd_ptr_next = '0;
                        if (pass_cnt == LAST_PASS) begin
                            pass_cnt_next = '0;
                            state_next    = S_LOAD;
                        end else begin
                            pass_cnt_next = pass_cnt + PASS_W'(1);
                        end
                    end else begin
                        rd_ptr_next = rd_ptr + PTR_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_LOAD;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pass_cnt <= '0;
        end else begin
            state    <= state_next;
            wr_ptr   <= wr_ptr_next;
            rd_ptr   <= rd_ptr_next;
            pass_cnt <= pass_cnt_next;
        end
    end

    // Weight storage is intentionally not reset; only a completed load makes
    // its contents visible, so stale data is never replayed.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_TILES; k++) begin
            if (rst && load_fire && (wr_ptr == PTR_W'(k))) begin
                mem[k] <= weight_in;
            end
        end
    end

endmodule

// File: tb/tb_fixed_linear_weight_buffer.sv
module tb_fixed_linear_weight_buffer;

    localparam int W  = 16;
    localparam int TW = 128;

    logic          clk = 1'b0;
    logic          rst;

    logic [TW-1:0] a_in;
    logic          a_in_valid;
    logic          a_in_ready;
    logic [TW-1:0] a_w;
    logic          a_valid;
    logic          a_ready;
    logic          a_last;

    logic [TW-1:0] b_in;
    logic          b_in_valid;
    logic          b_in_ready;
    logic [TW-1:0] b_w;
    logic          b_valid;
    logic          b_ready;
    logic          b_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fixed_linear_weight_buffer dut_a (
        .clk              (clk),
        .rst              (rst),
        .weight_in        (a_in),
        .weight_in_valid  (a_in_valid),
        .weight_in_ready  (a_in_ready),
        .weight           (a_w),
        .weight_valid     (a_valid),
        .weight_ready     (a_ready),
        .weight_pass_last (a_last)
    );

    fixed_linear_weight_buffer #(
        .WEIGHT_PRECISION_0          (16),
        .DATA_IN_0_PARALLELISM_DIM_0 (2),
        .WEIGHT_PARALLELISM_DIM_0    (4),
        .DATA_IN_0_TENSOR_SIZE_DIM_0 (2),
        .WEIGHT_TENSOR_SIZE_DIM_1    (4),
        .ROWS                        (1)
    ) dut_b (
        .clk              (clk),
        .rst              (rst),
        .weight_in        (b_in),
        .weight_in_valid  (b_in_valid),
        .weight_in_ready  (b_in_ready),
        .weight           (b_w),
        .weight_valid     (b_valid),
        .weight_ready     (b_ready),
        .weight_pass_last (b_last)
    );

    // Element j of tile k is 16*k+j.
    function automatic logic [TW-1:0] make_tile(input int k);
        logic [TW-1:0] t;
        t = '0;
        for (int j = 0; j < 8; j++) begin
            t[W*j +: W] = W'(16 * k + j);
        end
        return t;
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_matrix(input int base);
        for (int k = 0; k < 4; k++) begin
            a_in       = make_tile(base + k);
            a_in_valid = 1'b1;
            cyc();
        end
        a_in_valid = 1'b0;
        a_in       = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc();
        cyc();
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", a_in_ready);
        end
        checks++;
        if (a_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", a_valid);
        end
        checks++;
        if (a_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_pass_last: got %b expected 0", a_last);
        end
        checks++;
        if (b_in_ready !== 1'b1 || b_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: got ready=%b valid=%b expected ready=1 valid=0", b_in_ready, b_valid);
        end
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            a_in       = make_tile(k);
            a_in_valid = 1'b1;
            checks++;
            if (a_in_ready !== 1'b1 || a_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_load_%0d: got ready=%b valid=%b expected ready=1 valid=0", k, a_in_ready, a_valid);
            end
            cyc();
        end
        a_in_valid = 1'b0;
        a_ready    = 1'b1;
        for (int o = 0; o < 8; o++) begin
            checks++;
            if (a_valid !== 1'b1 || a_w !== make_tile(o % 4) || a_last !== (o % 4 == 3) || a_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_out_%0d: got valid=%b last=%b in_ready=%b w=%h expected tile %0d last=%b",
                         o, a_valid, a_last, a_in_ready, a_w, o % 4, (o % 4 == 3));
            end
            cyc();
        end
        checks++;
        if (a_in_ready !== 1'b1 || a_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reopen: got in_ready=%b valid=%b expected in_ready=1 valid=0", a_in_ready, a_valid);
        end
        a_ready = 1'b0;
    endtask

    task automatic test_gap();
        int seq [6] = '{0, 1, -1, -1, 2, 3};
        for (int c = 0; c < 6; c++) begin
            a_in_valid = (seq[c] >= 0);
            a_in       = (seq[c] >= 0) ? make_tile(seq[c]) : make_tile(30);
            checks++;
            if (a_valid !== 1'b0 || a_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL gap_load_%0d: got valid=%b in_ready=%b expected valid=0 in_ready=1", c, a_valid, a_in_ready);
            end
            cyc();
        end
        a_in_valid = 1'b0;
        a_ready    = 1'b1;
        for (int o = 0; o < 8; o++) begin
            checks++;
            if (a_valid !== 1'b1 || a_w !== make_tile(o % 4) || a_last !== (o % 4 == 3)) begin
                errors++;
                $display("FAIL gap_out_%0d: got valid=%b last=%b w=%h expected tile %0d", o, a_valid, a_last, a_w, o % 4);
            end
            cyc();
        end
        a_ready = 1'b0;
    endtask

    task automatic test_stall();
        int exp_t [11] = '{0, 1, 2, 2, 2, 2, 3, 0, 1, 2, 3};
        bit rdy   [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        load_matrix(0);
        for (int c = 0; c < 11; c++) begin
            a_ready = rdy[c];
            checks++;
            if (a_valid !== 1'b1 || a_w !== make_tile(exp_t[c]) || a_last !== (exp_t[c] == 3)) begin
                errors++;
                $display("FAIL stall_cyc_%0d: got valid=%b last=%b w=%h expected tile %0d", c, a_valid, a_last, a_w, exp_t[c]);
            end
            cyc();
        end
        a_ready = 1'b0;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_reopen: got in_ready=%b expected 1", a_in_ready);
        end
    endtask

    task automatic test_reset_mid();
        load_matrix(0);
        a_ready = 1'b1;
        for (int o = 0; o < 5; o++) begin
            checks++;
            if (a_w !== make_tile(o % 4)) begin
                errors++;
                $display("FAIL midrst_pre_%0d: got w=%h expected tile %0d", o, a_w, o % 4);
            end
            cyc();
        end
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        a_ready = 1'b0;
        checks++;
        if (a_valid !== 1'b0 || a_in_ready !== 1'b1 || a_last !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got valid=%b in_ready=%b last=%b expected 0 1 0", a_valid, a_in_ready, a_last);
        end
        // Partial load, then reset: the partial load must be discarded.
        for (int k = 0; k < 2; k++) begin
            a_in       = make_tile(12 + k);
            a_in_valid = 1'b1;
            cyc();
        end
        a_in_valid = 1'b0;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        load_matrix(8);
        a_ready = 1'b1;
        for (int o = 0; o < 8; o++) begin
            checks++;
            if (a_valid !== 1'b1 || a_w !== make_tile(8 + o % 4) || a_last !== (o % 4 == 3)) begin
                errors++;
                $display("FAIL midrst_out_%0d: got valid=%b last=%b w=%h expected tile %0d", o, a_valid, a_last, a_w, 8 + o % 4);
            end
            cyc();
        end
        a_ready = 1'b0;
    endtask

    task automatic test_load_blocked();
        load_matrix(4);
        a_in       = make_tile(20);
        a_in_valid = 1'b1;
        a_ready    = 1'b1;
        for (int o = 0; o < 8; o++) begin
            checks++;
            if (a_in_ready !== 1'b0 || a_w !== make_tile(4 + o % 4) || a_valid !== 1'b1) begin
                errors++;
                $display("FAIL blocked_out_%0d: got in_ready=%b valid=%b w=%h expected in_ready=0 tile %0d",
                         o, a_in_ready, a_valid, a_w, 4 + o % 4);
            end
            cyc();
        end
        a_in_valid = 1'b0;
        a_ready    = 1'b0;
        checks++;
        if (a_in_ready !== 1'b1 || a_valid !== 1'b0) begin
            errors++;
            $display("FAIL blocked_reopen: got in_ready=%b valid=%b expected 1 0", a_in_ready, a_valid);
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (b_in_ready !== 1'b1 || b_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_%0d_idle: got in_ready=%b valid=%b expected 1 0", i, b_in_ready, b_valid);
            end
            b_in       = make_tile(5 + i);
            b_in_valid = 1'b1;
            cyc();
            b_in_valid = 1'b0;
            b_ready    = 1'b1;
            checks++;
            if (b_valid !== 1'b1 || b_last !== 1'b1 || b_w !== make_tile(5 + i) || b_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL single_%0d_out: got valid=%b last=%b in_ready=%b w=%h expected tile %0d last=1",
                         i, b_valid, b_last, b_in_ready, b_w, 5 + i);
            end
            cyc();
            b_ready = 1'b0;
            checks++;
            if (b_in_ready !== 1'b1 || b_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_%0d_back: got in_ready=%b valid=%b expected 1 0", i, b_in_ready, b_valid);
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        a_in       = '0;
        a_in_valid = 1'b0;
        a_ready    = 1'b0;
        b_in       = '0;
        b_in_valid = 1'b0;
        b_ready    = 1'b0;
        #1;
        test_reset();
        test_back_to_back();
        test_gap();
        test_stall();
        test_reset_mid();
        test_load_blocked();
        test_single();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
